// File: rtl/seg7_scan_display.sv
// Scanned 8-digit hex display for the pipeline debug probe.
// Captured words are shown tear-free, starting only at a frame boundary.
module seg7_scan_display #(
    parameter int CLK_DIV = 50000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] DISP_data,
    input  logic        DISP_valid,
    input  logic        DISP_freeze,
    input  logic        DISP_blank_lz,
    output logic [7:0]  DISP_an,
    output logic [6:0]  DISP_seg,
    output logic        DISP_dp,
    output logic        DISP_frame_done,
    output logic [31:0] DISP_shown
);

    localparam int TW = $clog2(CLK_DIV);
    localparam logic [TW-1:0] TC = TW'(CLK_DIV - 1);

    logic [TW-1:0] tick_cnt;
    logic [2:0]    idx;
    logic [31:0]   shown;
    logic [31:0]   pending;
    logic          pend_v;

    logic          tick_tc;
    logic          boundary;
    logic [31:0]   upper;
    logic [3:0]    nib;
    logic          blanked;
    logic [6:0]    seg_hex;

    assign tick_tc    = (tick_cnt == TC);
    assign boundary   = tick_tc && (idx == 3'd7);
    assign upper      = shown >> {idx, 2'b00};
    assign nib        = upper[3:0];
    assign DISP_shown = shown;

    // Digit 0 is never blanked so an all-zero word still shows "0".
    assign blanked = DISP_blank_lz && (idx != 3'd0) && (upper == 32'd0);

    always_comb begin
        seg_hex = 7'h7F;
        unique case (nib)
            4'h0: seg_hex = 7'h40;
            4'h1: seg_hex = 7'h79;
            4'h2: seg_hex = 7'h24;
            4'h3: seg_hex = 7'h30;
            4'h4: seg_hex = 7'h19;
            4'h5: seg_hex = 7'h12;
            4'h6: seg_hex = 7'h02;
            4'h7: seg_hex = 7'h78;
            4'h8: seg_hex = 7'h00;
            4'h9: seg_hex = 7'h10;
            4'hA: seg_hex = 7'h08;
            4'hB: seg_hex = 7'h03;
            4'hC: seg_hex = 7'h46;
            4'hD: seg_hex = 7'h21;
            4'hE: seg_hex = 7'h06;
            4'hF: seg_hex = 7'h0E;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tick_cnt        <= '0;
            idx             <= 3'd0;
            shown           <= 32'd0;
            pending         <= 32'd0;
            pend_v          <= 1'b0;
            DISP_an         <= 8'hFF;
            DISP_seg        <= 7'h7F;
            DISP_dp         <= 1'b1;
            DISP_frame_done <= 1'b0;
        end else begin
            tick_cnt <= tick_tc ? '0 : tick_cnt + 1'b1;
            if (tick_tc)
                idx <= idx + 3'd1;
            if (DISP_valid) begin
                pending <= DISP_data;
                pend_v  <= 1'b1;
            end
            // A strobe on the boundary itself bypasses the pending register.
            if (boundary && !DISP_freeze && (DISP_valid || pend_v)) begin
                shown  <= DISP_valid ? DISP_data : pending;
                pend_v <= 1'b0;
            end
            DISP_frame_done <= boundary;
            DISP_an         <= blanked ? 8'hFF : ~(8'd1 << idx);
            DISP_seg        <= blanked ? 7'h7F : seg_hex;
            DISP_dp         <= !((idx == 3'd0) && pend_v);
        end
    end

endmodule
